// File: rtl/reg_dump_if.sv
// Dump output stream between reg_dump (master) and its consumer (slave).
// Words carry the register index plus last/checksum markers.
interface reg_dump_if #(
   parameter int DATA_W = 32
);
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [4:0]        dump_idx;
   logic              dump_last;
   logic              dump_is_chk;

   modport master (
      output dump_valid,
      output dump_data,
      output dump_idx,
      output dump_last,
      output dump_is_chk,
      input  dump_ready
   );

   modport slave (
      input  dump_valid,
      input  dump_data,
      input  dump_idx,
      input  dump_last,
      input  dump_is_chk,
      output dump_ready
   );
endinterface

// File: rtl/reg_dump.sv
// Sweeps a register file through its combinational read port and streams every word out with a valid/ready handshake.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start, outputs quiet
// S_FETCH | raddr = index, rdata is captured into the output word at the next edge
// S_SEND  | word presented, held until the consumer accepts it
// S_CHK   | checksum beat presented (only with REG_DUMP_CHECKSUM_EN)
// S_DONE  | one-cycle done pulse, then back to idle
module reg_dump #(
   parameter int NUM_REGS = 32,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [4:0]        raddr,
   input  logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   reg_dump_if.master        dump
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SEND  = 3'd2,
      S_DONE  = 3'd3
`ifdef REG_DUMP_CHECKSUM_EN
      ,
      S_CHK   = 3'd4
`endif
   } state_t;

`ifdef REG_DUMP_CHECKSUM_EN
   localparam state_t AFTER_LAST = S_CHK;
`else
   localparam state_t AFTER_LAST = S_DONE;
`endif

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        index;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [4:0]        idx_q;
   logic              last_q;
   logic              hs;

`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
   logic              chk_q;
`endif

   assign hs = valid_q & dump.dump_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (hs) begin
               state_nxt = (index == LAST_IDX) ? AFTER_LAST : S_FETCH;
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         S_CHK: begin
            if (hs) begin
               state_nxt = S_DONE;
            end
         end
`endif
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // raddr stays on the current index while its word is presented.
   always_comb begin
      busy  = (state != S_IDLE);
      done  = (state == S_DONE);
      raddr = 5'd0;
      if ((state == S_FETCH) || (state == S_SEND)) begin
         raddr = index;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index    <= 5'd0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         idx_q    <= 5'd0;
         last_q   <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         checksum <= '0;
         chk_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  index    <= 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
                  checksum <= '0;
`endif
               end
            end
            S_FETCH: begin
               valid_q  <= 1'b1;
               data_q   <= rdata;
               idx_q    <= index;
`ifdef REG_DUMP_CHECKSUM_EN
               last_q   <= 1'b0;
               chk_q    <= 1'b0;
               checksum <= checksum ^ rdata;
`else
               last_q   <= (index == LAST_IDX);
`endif
            end
            S_SEND: begin
               if (hs) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  if (index != LAST_IDX) begin
                     index <= index + 5'd1;
                  end
`ifdef REG_DUMP_CHECKSUM_EN
                  else begin
                     // Checksum beat goes out straight after the final register is accepted.
                     valid_q <= 1'b1;
                     data_q  <= checksum;
                     idx_q   <= 5'd0;
                     last_q  <= 1'b1;
                     chk_q   <= 1'b1;
                  end
`endif
               end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CHK: begin
               if (hs) begin
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  chk_q   <= 1'b0;
               end
            end
`endif
            S_DONE: begin
               index <= 5'd0;
            end
            default: begin
               index   <= 5'd0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign dump.dump_valid  = valid_q;
   assign dump.dump_data   = data_q;
   assign dump.dump_idx    = idx_q;
   assign dump.dump_last   = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
   assign dump.dump_is_chk = chk_q;
`else
   assign dump.dump_is_chk = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump.sv
// Directed self-checking bench for reg_dump: beat contents, timing, back-pressure, busy start, reset mid-dump.
// Honours REG_DUMP_CHECKSUM_EN the same way as the design.
module tb_reg_dump;
   localparam int NUM_REGS = 32;
   localparam int DATA_W   = 32;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam int NBEATS   = NUM_REGS + 1;
   localparam int DONE_CYC = 2 * NUM_REGS + 2;
`else
   localparam int NBEATS   = NUM_REGS;
   localparam int DONE_CYC = 2 * NUM_REGS + 1;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic [4:0]        raddr;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] regs [NUM_REGS];

   reg_dump_if #(.DATA_W(DATA_W)) dif ();

   reg_dump #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .raddr   (raddr),
      .rdata   (rdata),
      .busy    (busy),
      .done    (done),
      .dump    (dif.master)
   );

   always #5 clk = ~clk;
   assign rdata = regs[raddr];

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] b_data [$];
   int                b_idx  [$];
   logic              b_last [$];
   logic              b_chk  [$];
   int                b_cyc  [$];
   int                done_cnt;
   int                done_cyc;
   int                stall_seen;
   logic              stall_changed;

   task automatic clear_regs();
      for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
   endtask

   // Runs one dump from a start pulse; cycle numbers count edges after the one that sampled start.
   task automatic do_dump(input int stall_idx, input int stall_len, input int pulse_idx);
      logic [DATA_W-1:0] held_data;
      int                held_idx;
      logic              post_done;
      b_data.delete(); b_idx.delete(); b_last.delete(); b_chk.delete(); b_cyc.delete();
      done_cnt = 0; done_cyc = -1; stall_seen = 0; stall_changed = 1'b0; post_done = 1'b0;
      held_data = '0; held_idx = 0;
      @(negedge clk);
      start = 1'b1;
      dif.dump_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         start = (pulse_idx >= 0) && dif.dump_valid && (int'(dif.dump_idx) == pulse_idx);
         if (dif.dump_valid && !dif.dump_is_chk && int'(dif.dump_idx) == stall_idx && stall_seen < stall_len) begin
            dif.dump_ready = 1'b0;
            if (stall_seen == 0) begin
               held_data = dif.dump_data;
               held_idx  = int'(dif.dump_idx);
            end else if (dif.dump_data !== held_data || int'(dif.dump_idx) != held_idx) begin
               stall_changed = 1'b1;
            end
            stall_seen++;
         end else begin
            dif.dump_ready = 1'b1;
            if (stall_len > 0 && stall_seen == stall_len && !post_done) begin
               post_done = 1'b1;
               if (!dif.dump_valid || dif.dump_data !== held_data || int'(dif.dump_idx) != held_idx)
                  stall_changed = 1'b1;
            end
         end
         if (dif.dump_valid && dif.dump_ready) begin
            b_data.push_back(dif.dump_data);
            b_idx.push_back(int'(dif.dump_idx));
            b_last.push_back(dif.dump_last);
            b_chk.push_back(dif.dump_is_chk);
            b_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      end
      start = 1'b0;
      dif.dump_ready = 1'b1;
   endtask

   task automatic test_reset();
      dif.dump_ready = 1'b1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (dif.dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || raddr !== 5'd0 ||
          dif.dump_data !== '0 || dif.dump_idx !== 5'd0 || dif.dump_last !== 1'b0 || dif.dump_is_chk !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b busy=%b done=%b raddr=%0d data=%h idx=%0d last=%b chk=%b, required all zero",
                  dif.dump_valid, busy, done, raddr, dif.dump_data, dif.dump_idx, dif.dump_last, dif.dump_is_chk);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || dif.dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b valid=%b, required 0 0", busy, dif.dump_valid);
      end
   endtask

   task automatic test_single_reg();
      logic [DATA_W-1:0] ed;
      clear_regs();
      regs[21] = 32'h0F0F_0F0F;
      do_dump(-1, 0, -1);
      checks++;
      if (b_data.size() != NBEATS) begin
         errors++;
         $display("FAIL single_beat_count: got %0d, required %0d", b_data.size(), NBEATS);
      end
      for (int k = 0; k < b_data.size() && k < NUM_REGS; k++) begin
         ed = (k == 21) ? 32'h0F0F_0F0F : 32'h0;
         checks++;
         if (b_data[k] !== ed || b_idx[k] != k || b_chk[k] !== 1'b0 ||
             b_last[k] !== (k == NBEATS - 1) || b_cyc[k] != 2 + 2 * k) begin
            errors++;
            $display("FAIL single_beat_%0d: got data=%h idx=%0d last=%b chk=%b edge=N+%0d, required data=%h idx=%0d last=%b chk=0 edge=N+%0d",
                     k, b_data[k], b_idx[k], b_last[k], b_chk[k], b_cyc[k], ed, k, (k == NBEATS - 1), 2 + 2 * k);
         end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      checks++;
      if (b_data.size() != NBEATS || b_data[NUM_REGS] !== 32'h0F0F_0F0F || b_idx[NUM_REGS] != 0 ||
          b_chk[NUM_REGS] !== 1'b1 || b_last[NUM_REGS] !== 1'b1 || b_cyc[NUM_REGS] != 2 * NUM_REGS + 1) begin
         errors++;
         $display("FAIL single_checksum_beat: missing or wrong, required data=0f0f0f0f idx=0 chk=1 last=1 edge=N+%0d",
                  2 * NUM_REGS + 1);
      end
`endif
      checks++;
      if (done_cnt != 1 || done_cyc != DONE_CYC) begin
         errors++;
         $display("FAIL single_done: got %0d pulses first at N+%0d, required 1 pulse at N+%0d", done_cnt, done_cyc, DONE_CYC);
      end
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] ed;
      int                ey;
      clear_regs();
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'hA500_0000 | i;
      do_dump(3, 5, -1);
      checks++;
      if (stall_seen != 5 || stall_changed !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold: got stalled_cycles=%0d changed=%b, required 5 and 0", stall_seen, stall_changed);
      end
      checks++;
      if (b_data.size() != NBEATS) begin
         errors++;
         $display("FAIL stall_beat_count: got %0d, required %0d", b_data.size(), NBEATS);
      end
      for (int k = 0; k < b_data.size() && k < NUM_REGS; k++) begin
         ed = 32'hA500_0000 | k;
         ey = (k < 3) ? 2 + 2 * k : 7 + 2 * k;
         checks++;
         if (b_data[k] !== ed || b_idx[k] != k || b_cyc[k] != ey) begin
            errors++;
            $display("FAIL stall_beat_%0d: got data=%h idx=%0d edge=N+%0d, required data=%h idx=%0d edge=N+%0d",
                     k, b_data[k], b_idx[k], b_cyc[k], ed, k, ey);
         end
      end
      checks++;
      if (done_cnt != 1 || done_cyc != DONE_CYC + 5) begin
         errors++;
         $display("FAIL stall_done: got %0d pulses first at N+%0d, required 1 pulse at N+%0d", done_cnt, done_cyc, DONE_CYC + 5);
      end
   endtask

   task automatic test_start_while_busy();
      clear_regs();
      for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h0000_0100 + i;
      do_dump(-1, 0, 7);
      checks++;
      if (b_data.size() != NBEATS || done_cnt != 1 || done_cyc != DONE_CYC) begin
         errors++;
         $display("FAIL busy_start: got beats=%0d done_pulses=%0d done_at=N+%0d, required %0d 1 N+%0d",
                  b_data.size(), done_cnt, done_cyc, NBEATS, DONE_CYC);
      end
      for (int k = 0; k < b_data.size() && k < NUM_REGS; k++) begin
         checks++;
         if (b_idx[k] != k || b_data[k] !== (32'h0000_0100 + k)) begin
            errors++;
            $display("FAIL busy_start_beat_%0d: got idx=%0d data=%h, required idx=%0d data=%h",
                     k, b_idx[k], b_data[k], k, 32'h0000_0100 + k);
         end
      end
   endtask

   task automatic test_reset_mid_dump();
      logic found;
      clear_regs();
      regs[0] = 32'h1111_1111;
      regs[10] = 32'h0000_AAAA;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (dif.dump_valid && dif.dump_idx == 5'd10) found = 1'b1;
      end
      checks++;
      if (!found || raddr !== 5'd10 || busy !== 1'b1 || dif.dump_data !== 32'h0000_AAAA) begin
         errors++;
         $display("FAIL mid_reach_idx10: got found=%b raddr=%0d busy=%b data=%h, required 1 10 1 0000aaaa",
                  found, raddr, busy, dif.dump_data);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (dif.dump_valid !== 1'b0 || busy !== 1'b0 || raddr !== 5'd0 || done !== 1'b0 ||
          dif.dump_data !== '0 || dif.dump_idx !== 5'd0) begin
         errors++;
         $display("FAIL mid_async_reset: got valid=%b busy=%b raddr=%0d done=%b data=%h idx=%0d, required all zero",
                  dif.dump_valid, busy, raddr, done, dif.dump_data, dif.dump_idx);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      do_dump(-1, 0, -1);
      checks++;
      if (b_data.size() != NBEATS || b_idx[0] != 0 || b_data[0] !== 32'h1111_1111 || b_cyc[0] != 2) begin
         errors++;
         $display("FAIL mid_restart: got beats=%0d, first idx/data/edge wrong, required %0d beats starting idx=0 data=11111111 at N+2",
                  b_data.size(), NBEATS);
      end
      checks++;
      if (b_data.size() == NBEATS && b_data[10] !== 32'h0000_AAAA) begin
         errors++;
         $display("FAIL mid_restart_idx10: got %h, required 0000aaaa", b_data[10]);
      end
   endtask

   task automatic test_back_to_back();
      clear_regs();
      regs[0]  = 32'hDEAD_BEEF;
      regs[31] = 32'h8000_0001;
      for (int pass = 0; pass < 2; pass++) begin
         do_dump(-1, 0, -1);
         checks++;
         if (b_data.size() != NBEATS || b_data[0] !== 32'hDEAD_BEEF || b_data[31] !== 32'h8000_0001 ||
             b_idx[31] != 31 || done_cnt != 1) begin
            errors++;
            $display("FAIL b2b_pass%0d: got beats=%0d done_pulses=%0d, required %0d beats reg0=deadbeef reg31=80000001 and 1 done",
                     pass, b_data.size(), done_cnt, NBEATS);
         end
`ifdef REG_DUMP_CHECKSUM_EN
         checks++;
         if (b_data.size() != NBEATS || b_data[32] !== 32'h5EAD_BEEE || b_chk[32] !== 1'b1 || b_last[31] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_checksum_pass%0d: required chk beat 5eadbeee with data beat 31 not last", pass);
         end
`else
         checks++;
         if (b_data.size() != NBEATS || b_last[31] !== 1'b1 || b_last[30] !== 1'b0 || b_chk[31] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_last_pass%0d: required last only on idx 31 and no checksum flag", pass);
         end
`endif
      end
   endtask

`ifdef REG_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      clear_regs();
      regs[1] = 32'h2222_22FF;
      regs[2] = 32'h0000_00FF;
      do_dump(-1, 0, -1);
      checks++;
      if (b_data.size() != NBEATS || b_data[32] !== 32'h2222_2200 || b_idx[32] != 0 ||
          b_chk[32] !== 1'b1 || b_last[32] !== 1'b1) begin
         errors++;
         $display("FAIL checksum_xor: got beats=%0d, required checksum beat 22222200 idx=0 chk=1 last=1", b_data.size());
      end
   endtask
`endif

   initial begin
      dif.dump_ready = 1'b1;
      clear_regs();
      test_reset();
      test_single_reg();
      test_stall();
      test_start_while_busy();
      test_reset_mid_dump();
      test_back_to_back();
`ifdef REG_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers swept (2..32).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request a full register-file dump.
REQ-006 SHALL have port raddr  output  5  read address driven to the register file read port.
REQ-007 SHALL have port rdata  input  DATA_W  combinational read data returned for raddr in the same cycle.
REQ-008 SHALL have port dump_valid  output  1  dump word available.
REQ-009 SHALL have port dump_ready  input  1  consumer accepts the word.
REQ-010 SHALL have port dump_data  output  DATA_W  dumped word.
REQ-011 SHALL have port dump_idx  output  5  register index of dump_data.
REQ-012 SHALL have port dump_last  output  1  final beat of the dump.
REQ-013 SHALL have port dump_is_chk  output  1  current beat is the checksum word.
REQ-014 SHALL have port busy  output  1  dump in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SEND, CHK, DONE.
REQ-017 IDLE: start=1 at an edge -> FETCH, index=0; start otherwise ignored.
REQ-018 FETCH: raddr=index; next edge captures rdata into dump_data, dump_idx=index, dump_valid=1 -> SEND.
REQ-019 SEND: dump_data, dump_idx, dump_last, dump_is_chk SHALL hold stable while dump_valid=1 and dump_ready=0.
REQ-020 Handshake occurs on an edge with dump_valid=1 and dump_ready=1; dump_valid SHALL drop that edge.
REQ-021 After handshake: index<NUM_REGS-1 -> index+1, FETCH; index=NUM_REGS-1 -> CHK if checksum compiled in, else DONE.
REQ-022 Throughput SHALL be one word per two cycles with dump_ready held high; first dump_valid high after the edge following the one that sampled start.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 busy SHALL be 1 in FETCH, SEND, CHK, DONE; 0 in IDLE.
REQ-025 start SHALL be ignored while busy=1; no restart, no effect on index.
REQ-026 raddr SHALL be 0 in IDLE, DONE, CHK.
REQ-027 Register 0 SHALL be dumped as read (0 from a correct register file); no special-casing.
REQ-028 dump_last SHALL be 1 only on the final beat of a dump.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, index=0, raddr=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, dump_is_chk=0, busy=0, done=0, checksum=0.
REQ-030 Reset mid-dump SHALL abandon the dump; the next start restarts at index 0.

Configuration
REQ-031 Macro REG_DUMP_CHECKSUM_EN defined: running XOR of all NUM_REGS dumped words SHALL be emitted in CHK as one extra beat (dump_data=XOR, dump_idx=0, dump_is_chk=1, dump_last=1), same handshake rules, then DONE.
REQ-032 Macro undefined: no CHK state, no checksum logic; dump_is_chk tied 0; dump_last=1 on the index NUM_REGS-1 beat.

Verification
REQ-033 Reg 21 written 0x0F0F0F0F, others 0; start, ready=1 -> beat idx 21 = 0x0F0F0F0F, all other beats 0x00000000; with macro checksum beat = 0x0F0F0F0F.
REQ-034 ready=1 throughout, start sampled edge N -> 32 beats at edges N+2, N+4, ... N+64; done high for one cycle (no macro) after edge N+64.
REQ-035 dump_ready low 5 cycles while dump_idx=3 -> dump_valid, dump_data, dump_idx stay constant; beat 4 follows only after handshake.
REQ-036 start pulsed at dump_idx=7 -> ignored; dump continues to idx 31, exactly one done pulse.
REQ-037 reset_n low while dump_idx=10 -> dump_valid, busy, raddr go 0 without clock edge; after release, start -> first beat dump_idx=0.
REQ-038 Reg 1=0x222222FF, reg 2=0x000000FF, others 0, macro defined -> checksum beat 0x22222200, dump_is_chk=1, dump_last=1.
